// File: rtl/cordic_iter_seq.sv
// Iterative CORDIC sequencer in rotation mode: loads an angle, runs STEPS micro-rotations
// with an internal arctangent ROM, and returns cos/sin over a valid/ready handshake.
module cordic_iter_seq #(
   parameter int BITS  = 16,
   parameter int STEPS = 14
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [BITS-1:0] in_angle,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [BITS-1:0] out_cos,
   output logic signed [BITS-1:0] out_sin,
   output logic                   range_err
);

   localparam int unsigned SW = $clog2(STEPS);
   localparam logic signed [BITS-1:0] K_INIT  = BITS'(9949);
   localparam logic signed [BITS-1:0] ANG_MAX = BITS'(25736);
   localparam logic signed [BITS-1:0] ANG_MIN = -ANG_MAX;
   localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t state, state_nx;

   logic signed [BITS-1:0] x, y, z;
   logic [SW-1:0] step;
   logic fin;
   logic accept, iter_en, finish, drain;
   logic signed [BITS-1:0] ang_z, atan_c, x_sh, y_sh, x_nx, y_nx, z_nx;
   logic ang_clamp, dir;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)  state_nx = ITER;
         ITER:    if (fin)       state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      in_ready = (state == IDLE);
      accept   = (state == IDLE) && in_valid;
      iter_en  = (state == ITER) && !fin;
      finish   = (state == ITER) && fin;
      drain    = (state == DONE) && out_ready;
   end

   // Input angle saturation to +/- pi/2
   always_comb begin
      ang_z     = in_angle;
      ang_clamp = 1'b0;
      if (in_angle > ANG_MAX) begin
         ang_z     = ANG_MAX;
         ang_clamp = 1'b1;
      end else if (in_angle < ANG_MIN) begin
         ang_z     = ANG_MIN;
         ang_clamp = 1'b1;
      end
   end

   // Arctangent ROM, atan(2^-i) in Q2.14
   always_comb begin
      atan_c = '0;
      case (int'(step))
         0:  atan_c = BITS'(12867);
         1:  atan_c = BITS'(7596);
         2:  atan_c = BITS'(4013);
         3:  atan_c = BITS'(2037);
         4:  atan_c = BITS'(1022);
         5:  atan_c = BITS'(511);
         6:  atan_c = BITS'(255);
         7:  atan_c = BITS'(127);
         8:  atan_c = BITS'(63);
         9:  atan_c = BITS'(31);
         10: atan_c = BITS'(15);
         11: atan_c = BITS'(7);
         12: atan_c = BITS'(3);
         13: atan_c = BITS'(1);
         default: atan_c = '0;
      endcase
   end

   // One micro-rotation, direction chosen by the sign of the residual angle
   always_comb begin
      dir  = ~z[BITS-1];
      x_sh = x >>> step;
      y_sh = y >>> step;
      if (dir) begin
         x_nx = x - y_sh;
         y_nx = y + x_sh;
         z_nx = z - atan_c;
      end else begin
         x_nx = x + y_sh;
         y_nx = y - x_sh;
         z_nx = z + atan_c;
      end
   end

   // Datapath and result registers; fin marks that the last rotation has landed in x/y
   always_ff @(posedge clk) begin
      if (rst) begin
         x         <= '0;
         y         <= '0;
         z         <= '0;
         step      <= '0;
         fin       <= 1'b0;
         out_valid <= 1'b0;
         out_cos   <= '0;
         out_sin   <= '0;
         range_err <= 1'b0;
      end else begin
         if (accept) begin
            x         <= K_INIT;
            y         <= '0;
            z         <= ang_z;
            step      <= '0;
            fin       <= 1'b0;
            range_err <= ang_clamp;
         end
         if (iter_en) begin
            x    <= x_nx;
            y    <= y_nx;
            z    <= z_nx;
            fin  <= (step == LAST_STEP);
            step <= (step == LAST_STEP) ? step : step + SW'(1);
         end
         if (finish) begin
            out_cos   <= x;
            out_sin   <= y;
            out_valid <= 1'b1;
         end
         if (drain) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cordic_iter_seq.sv
// Scoreboard bench for cordic_iter_seq: a driver queues expected results from a
// bit-accurate algorithmic model, a monitor pops and compares as results appear.
module tb_cordic_iter_seq;

   logic clk, rst, in_valid, in_ready, out_valid, out_ready, range_err;
   logic signed [15:0] in_angle, out_cos, out_sin;

   cordic_iter_seq #(.BITS(16), .STEPS(14)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
      .out_valid(out_valid), .out_ready(out_ready), .out_cos(out_cos), .out_sin(out_sin),
      .range_err(range_err)
   );

   typedef struct {
      int acc;
      int zc;
      int bp;
      logic signed [15:0] c;
      logic signed [15:0] s;
      logic err;
   } exp_t;

   localparam int ATAN [14] = '{12867, 7596, 4013, 2037, 1022, 511, 255, 127, 63, 31, 15, 7, 3, 1};

   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_near(input string name, input int act, input int exp, input int tol);
      checks++;
      if (act - exp > tol || exp - act > tol) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   // Reference: saturate, then run the CORDIC recurrence directly on 16-bit wrapping integers
   function automatic exp_t model(input int ang);
      exp_t e;
      logic signed [15:0] x, y, z, xs, ys;
      e.zc  = (ang > 25736) ? 25736 : (ang < -25736) ? -25736 : ang;
      e.err = (ang > 25736) || (ang < -25736);
      x = 16'sd9949;
      y = 16'sd0;
      z = 16'(e.zc);
      for (int i = 0; i < 14; i++) begin
         xs = x >>> i;
         ys = y >>> i;
         if (z >= 16'sd0) begin
            x = x - ys;  y = y + xs;  z = z - 16'(ATAN[i]);
         end else begin
            x = x + ys;  y = y - xs;  z = z + 16'(ATAN[i]);
         end
      end
      e.c = x;
      e.s = y;
      e.acc = 0;
      e.bp = 0;
      return e;
   endfunction

   // Driver: junk in_valid pulses while busy, real angle once in_ready is seen
   task automatic send(input int ang, input int bp, output bit ok);
      exp_t e;
      int waited = 0;
      ok = 1'b0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         in_valid = 1'($urandom_range(0, 1));
         in_angle = 16'($urandom_range(0, 65535));
         if (++waited > 100) begin
            check("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b1;
      in_angle = 16'(ang);
      e = model(ang);
      e.acc = cyc + 1;
      e.bp = bp;
      q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      in_angle = 16'($urandom_range(0, 65535));
      ok = 1'b1;
   endtask

   // Monitor: pops expectation on first valid cycle, checks hold stability and drain
   initial begin : monitor
      exp_t cur;
      bit held, drained;
      int hold;
      logic signed [15:0] cap_c, cap_s;
      logic cap_e;
      real ic, is;
      held = 0; drained = 0; hold = 0;
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 0; drained = 0; out_ready = 1'b0;
            continue;
         end
         if (drained) begin
            check("drain_out_valid", int'(out_valid), 0);
            check("drain_in_ready", int'(in_ready), 1);
            drained = 0;
         end
         if (out_valid) begin
            if (!held) begin
               if (q.size() == 0) begin
                  check("unexpected_out_valid", 1, 0);
                  hold = 0;
               end else begin
                  cur = q.pop_front();
                  check("latency", cyc - cur.acc, 15);
                  check("out_cos", int'(out_cos), int'(cur.c));
                  check("out_sin", int'(out_sin), int'(cur.s));
                  check("range_err", int'(range_err), int'(cur.err));
                  ic = $cos(real'(cur.zc) / 16384.0) * 16384.0;
                  is = $sin(real'(cur.zc) / 16384.0) * 16384.0;
                  check_near("cos_ideal", int'(out_cos), $rtoi(ic), 16);
                  check_near("sin_ideal", int'(out_sin), $rtoi(is), 16);
                  hold = cur.bp;
               end
               cap_c = out_cos; cap_s = out_sin; cap_e = range_err;
               held = 1;
            end else begin
               check("hold_cos", int'(out_cos), int'(cap_c));
               check("hold_sin", int'(out_sin), int'(cap_s));
               check("hold_err", int'(range_err), int'(cap_e));
               check("hold_in_ready", int'(in_ready), 0);
            end
            if (hold == 0) begin
               out_ready = 1'b1;
               held = 0;
               drained = 1;
            end else begin
               hold--;
               out_ready = 1'b0;
            end
         end else begin
            out_ready = 1'b0;
         end
      end
   end

   initial begin : stim
      bit ok;
      int angles [6] = '{0, 12868, -8579, 25736, 30000, -30000};
      int bps    [6] = '{0, 2, 5, 0, 1, 0};
      int budget;
      rst = 1'b1; in_valid = 1'b0; in_angle = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_cos", int'(out_cos), 0);
      check("rst_out_sin", int'(out_sin), 0);
      check("rst_range_err", int'(range_err), 0);
      rst = 1'b0;

      foreach (angles[i]) send(angles[i], bps[i], ok);

      // Reset while iteration step 7 is being applied
      send(9000, 0, ok);
      if (ok) begin
         repeat (7) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         void'(q.pop_back());
         check("midrst_in_ready", int'(in_ready), 1);
         check("midrst_out_valid", int'(out_valid), 0);
         check("midrst_out_cos", int'(out_cos), 0);
         check("midrst_out_sin", int'(out_sin), 0);
      end
      send(0, 0, ok);

      for (int n = 0; n < 25; n++)
         send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 3)), ok);

      budget = 0;
      while ((q.size() != 0 || out_valid) && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 200) check("final_drain_timeout", q.size(), 0);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
